// File: rtl/axis_frame_fifo.sv
// First-word-fall-through buffer for the converter's tnext/tvalid/tfirst stream.
// Reports stored-word occupancy and the number of frame starts currently held.
module axis_frame_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic         s_axis_tnext,
  input  logic [W-1:0] s_axis_tdata,
  input  logic         s_axis_tfirst,
  input  logic         s_axis_tvalid,
  input  logic         m_axis_tnext,
  output logic [W-1:0] m_axis_tdata,
  output logic         m_axis_tfirst,
  output logic         m_axis_tvalid,
  output logic [15:0]  level,
  output logic [15:0]  frames
);

  localparam int AW = $clog2(DEPTH);

  logic [W:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   frame_cnt;
  logic [W:0]    head;
  logic          full;
  logic          push;
  logic          pop;
  logic          push_first;
  logic          pop_first;

  // DEPTH is a power of two and count never exceeds it, so the MSB alone marks full.
  assign full       = count[AW];
  assign head       = mem[rd_ptr];

  assign s_axis_tnext  = rst & ~full;
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = head[W-1:0];
  assign m_axis_tfirst = head[W] & m_axis_tvalid;

  assign push       = s_axis_tvalid & s_axis_tnext;
  assign pop        = m_axis_tvalid & m_axis_tnext;
  assign push_first = push & s_axis_tfirst;
  assign pop_first  = pop & head[W];

  always_comb begin
    level           = '0;
    level[AW:0]     = count;
    frames          = '0;
    frames[AW:0]    = frame_cnt;
  end

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= {s_axis_tfirst, s_axis_tdata};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      count     <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      frame_cnt <= frame_cnt + {{AW{1'b0}}, push_first} - {{AW{1'b0}}, pop_first};
    end
  end

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Bench for axis_frame_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axis_frame_fifo;

  localparam int W     = 3;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic         s_axis_tnext;
  logic [W-1:0] s_axis_tdata = '0;
  logic         s_axis_tfirst = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         m_axis_tnext = 1'b0;
  logic [W-1:0] m_axis_tdata;
  logic         m_axis_tfirst;
  logic         m_axis_tvalid;
  logic [15:0]  level;
  logic [15:0]  frames;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  logic [W:0] model_q[$];

  axis_frame_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .s_axis_tnext  (s_axis_tnext),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tfirst (s_axis_tfirst),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tnext  (m_axis_tnext),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tfirst (m_axis_tfirst),
    .m_axis_tvalid (m_axis_tvalid),
    .level         (level),
    .frames        (frames)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue of {tfirst, tdata}.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
    end else begin
      bit do_push, do_pop;
      do_push = s_axis_tvalid && (model_q.size() < DEPTH);
      do_pop  = m_axis_tnext && (model_q.size() > 0);
      if (clr) begin
        model_q.delete();
      end else begin
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back({s_axis_tfirst, s_axis_tdata});
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      int nfirst;
      nfirst = 0;
      foreach (model_q[i]) if (model_q[i][W]) nfirst++;
      chk("cyc_tnext",  {31'd0, s_axis_tnext}, {31'd0, (rst && model_q.size() < DEPTH)});
      chk("cyc_tvalid", {31'd0, m_axis_tvalid}, {31'd0, (model_q.size() > 0)});
      chk("cyc_level",  {16'd0, level}, model_q.size());
      chk("cyc_frames", {16'd0, frames}, nfirst);
      if (model_q.size() > 0) begin
        chk("cyc_tdata",  {29'd0, m_axis_tdata}, {29'd0, model_q[0][W-1:0]});
        chk("cyc_tfirst", {31'd0, m_axis_tfirst}, {31'd0, model_q[0][W]});
      end else begin
        chk("cyc_tfirst_empty", {31'd0, m_axis_tfirst}, 32'd0);
      end
    end
  end

  initial begin
    logic [W:0]  seq [48];
    logic [39:0] fpat;
    fpat = 40'h9_3A_C5_61_B7;

    #2 rst = 1'b0;
    started = 1'b1;
    step();
    step();
    chk("rst_tnext", {31'd0, s_axis_tnext}, 32'd0);
    chk("rst_level", {16'd0, level}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_tnext", {31'd0, s_axis_tnext}, 32'd1);

    // Fill with consumer stalled, then offer a 17th word.
    for (int i = 0; i < 16; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = W'(i % 8);
      s_axis_tfirst = (i == 0);
      step();
    end
    chk("fill_level", {16'd0, level}, 32'd16);
    chk("fill_tnext", {31'd0, s_axis_tnext}, 32'd0);
    s_axis_tdata  = 3'd7;
    s_axis_tfirst = 1'b1;
    step();
    step();
    chk("fill_17th_rejected", {16'd0, level}, 32'd16);
    chk("fill_frames", {16'd0, frames}, 32'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tfirst = 1'b0;

    // Drain in order, one per cycle.
    m_axis_tnext = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", {29'd0, m_axis_tdata}, i % 8);
      step();
    end
    chk("drain_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("drain_level", {16'd0, level}, 32'd0);
    m_axis_tnext = 1'b0;

    // Frames of length 5/2/4.
    for (int i = 0; i < 11; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = W'(i);
      s_axis_tfirst = (i == 0 || i == 5 || i == 7);
      step();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tfirst = 1'b0;
    chk("frm_frames", {16'd0, frames}, 32'd3);
    chk("frm_level", {16'd0, level}, 32'd11);
    m_axis_tnext = 1'b1;
    repeat (6) step();
    m_axis_tnext = 1'b0;
    chk("frm_frames_after_pop", {16'd0, frames}, 32'd1);
    chk("frm_level_after_pop", {16'd0, level}, 32'd5);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("frm_clr_level", {16'd0, level}, 32'd0);

    // Steady push+pop at level 8; output is input delayed by 8 words.
    for (int i = 0; i < 48; i++) begin
      logic [2:0] d;
      d = 3'((i * 3 + 1) % 8);
      seq[i] = {(i >= 8) ? fpat[i-8] : 1'b0, d};
    end
    for (int i = 0; i < 8; i++) begin
      s_axis_tvalid = 1'b1;
      {s_axis_tfirst, s_axis_tdata} = seq[i];
      step();
    end
    chk("ss_prefill_level", {16'd0, level}, 32'd8);
    m_axis_tnext = 1'b1;
    for (int j = 0; j < 40; j++) begin
      {s_axis_tfirst, s_axis_tdata} = seq[j + 8];
      chk("ss_head", {28'd0, m_axis_tfirst, m_axis_tdata}, {28'd0, seq[j]});
      step();
      chk("ss_level", {16'd0, level}, 32'd8);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tfirst = 1'b0;
    for (int j = 40; j < 48; j++) begin
      chk("ss_tail", {28'd0, m_axis_tfirst, m_axis_tdata}, {28'd0, seq[j]});
      step();
    end
    m_axis_tnext = 1'b0;
    chk("ss_empty", {16'd0, level}, 32'd0);

    // Full with consumer ready: pop only on the first cycle.
    for (int i = 0; i < 16; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = W'(7 - (i % 8));
      step();
    end
    chk("full_level", {16'd0, level}, 32'd16);
    s_axis_tdata = 3'd5;
    m_axis_tnext = 1'b1;
    step();
    chk("full_pop_only", {16'd0, level}, 32'd15);
    step();
    chk("full_push_pop", {16'd0, level}, 32'd15);
    s_axis_tvalid = 1'b0;
    m_axis_tnext  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Flush alongside a push.
    for (int i = 0; i < 9; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = W'(i);
      s_axis_tfirst = (i == 0 || i == 4);
      step();
    end
    chk("flush_pre_level", {16'd0, level}, 32'd9);
    chk("flush_pre_frames", {16'd0, frames}, 32'd2);
    clr = 1'b1;
    s_axis_tfirst = 1'b1;
    step();
    clr = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tfirst = 1'b0;
    chk("flush_level", {16'd0, level}, 32'd0);
    chk("flush_frames", {16'd0, frames}, 32'd0);
    chk("flush_tvalid", {31'd0, m_axis_tvalid}, 32'd0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = W'(i + 2);
      s_axis_tfirst = (i == 0);
      step();
    end
    m_axis_tnext = 1'b1;
    step();
    #2 rst = 1'b0;
    #1;
    chk("arst_tnext", {31'd0, s_axis_tnext}, 32'd0);
    chk("arst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("arst_tfirst", {31'd0, m_axis_tfirst}, 32'd0);
    chk("arst_level", {16'd0, level}, 32'd0);
    chk("arst_frames", {16'd0, frames}, 32'd0);
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tfirst = 1'b0;
    m_axis_tnext  = 1'b0;
    rst = 1'b1;
    step();
    chk("arst_release_tnext", {31'd0, s_axis_tnext}, 32'd1);
    chk("arst_release_level", {16'd0, level}, 32'd0);
    step();

    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_frame_fifo.md
# axis_frame_fifo

Synchronous first-word-fall-through buffer for the tnext/tvalid/tfirst stream produced by the width converter. It sits directly downstream of the converter's master port and absorbs bursts while the consumer stalls. It reports buffer occupancy and the number of frame starts currently held.

## Interface
- W, 3: data width; matches the converter's output width M.
- DEPTH, 16: number of entries; power of two, 2..32768.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; empties the buffer.
- s_axis_tnext  out  1  ready; a word transfers on a rising edge where s_axis_tvalid and s_axis_tnext are both 1.
- s_axis_tdata  in  W  input word.
- s_axis_tfirst  in  1  the input word starts a frame.
- s_axis_tvalid  in  1  the input word is valid.
- m_axis_tnext  in  1  consumer ready; a word pops on an edge where m_axis_tvalid and m_axis_tnext are both 1.
- m_axis_tdata  out  W  head word; meaningful only while m_axis_tvalid is 1.
- m_axis_tfirst  out  1  tfirst flag of the head word; 0 while m_axis_tvalid is 0.
- m_axis_tvalid  out  1  buffer is non-empty.
- level  out  16  number of stored words, zero-extended.
- frames  out  16  number of stored words whose tfirst is 1, zero-extended.

## Operation
- Storage: DEPTH entries of {tfirst, tdata}, with W+1 bits per entry. Memory contents are not reset.
- Pointers: a write pointer and a read pointer, each log2(DEPTH) bits, both wrapping modulo DEPTH. A count register of log2(DEPTH)+1 bits holds the occupancy.
- push = s_axis_tvalid & s_axis_tnext.
- pop = m_axis_tvalid & m_axis_tnext.
- On push: store the entry at the write pointer, then increment the write pointer.
- On pop: increment the read pointer.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- frames update: +1 when a pushed word has tfirst=1; -1 when the popped head word has tfirst=1; net sum of the two when both happen in the same cycle.
- s_axis_tnext = (count != DEPTH) & rst deasserted. It is a function of registers only and never depends on s_axis_tvalid or m_axis_tnext.
- Full buffer: no push is accepted, even if a pop happens in the same cycle. There is no pass-through when full.
- Empty buffer: no bypass. A word pushed into an empty buffer appears at the head on the next cycle.
- m_axis_tvalid = (count != 0).
- m_axis_tdata and m_axis_tfirst are read from the read-pointer entry. m_axis_tfirst is gated by m_axis_tvalid.
- clr=1 at an edge:
  - pointers, count and frames go to 0;
  - push and pop in that cycle are discarded;
  - clr takes priority over both.
- The tfirst flag is stored and forwarded unmodified. There is no frame validation.

## Timing
- Values while rst=0 and after rst is released:
  - s_axis_tnext 0 while rst=0, then 1 from the first cycle after release;
  - m_axis_tvalid 0;
  - m_axis_tfirst 0;
  - level 0;
  - frames 0.
- Latency: a word pushed at edge k is presented on m_axis from edge k onward, i.e. it is visible in cycle k+1. Minimum input-to-output latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- level, frames, s_axis_tnext and m_axis_tvalid all update at the same edge as the push/pop/clr that changes them.
- Head stability: while m_axis_tvalid=1 and m_axis_tnext=0, m_axis_tdata and m_axis_tfirst hold stable.
- Reset mid-operation: asynchronous clear of all state.
  - Any partially delivered frame is lost.
  - Outputs take their reset values immediately, not at the next edge.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.
- Boundary: level reaches exactly DEPTH. With DEPTH=32768, level=0x8000.

## Test plan
- Fill while m_axis_tnext=0, DEPTH=16:
  - push 16 words 0..15 (tdata mod 8), then drive a 17th;
  - required: s_axis_tnext drops after the 16th push, level=16, the 17th word is not accepted.
- Drain after fill:
  - m_axis_tnext=1;
  - required: words pop in push order, one per cycle; m_axis_tvalid falls after the 16th pop; level returns to 0.
- Frame counting:
  - push a 3-frame stream of frame lengths 5/2/4, with tfirst on words 0, 5 and 7; do not pop;
  - required: frames=3, level=11;
  - then pop 6 words; required: frames=1.
- Simultaneous push and pop at level=8 for 40 cycles with a random tfirst pattern:
  - required: level stays 8, the output sequence equals the input sequence delayed by 8 words, and pointers wrap at least twice.
- Full with consumer ready:
  - at level=16, set s_axis_tvalid=1 and m_axis_tnext=1;
  - required: the first cycle pops only, level=15; the next cycle pushes and pops, level holds at 15.
- Flush and reset:
  - at level=9 and frames=2, assert clr for one cycle alongside a push; required: level=0, frames=0, m_axis_tvalid=0;
  - drop rst mid-burst; required: all outputs reach their reset values before the next edge.
